// File: rtl/jam_pkg.sv
// Shared definitions for the assignment-problem cost table: widths, table geometry
// and the load/lookup state machine encoding.
package jam_pkg;

  localparam int N_WORKER = 8;
  localparam int COST_W   = 7;
  localparam int SUM_W    = 10;
  localparam int CNT_W    = 4;

  localparam int IDX_W    = $clog2(N_WORKER);
  localparam int PTR_W    = 2 * IDX_W;
  localparam int N_ENTRY  = N_WORKER * N_WORKER;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Row-major placement: a worker's eight job costs are contiguous.
  function automatic logic [PTR_W-1:0] entry_addr(input logic [IDX_W-1:0] w,
                                                  input logic [IDX_W-1:0] j);
    return {w, j};
  endfunction

endpackage

// File: rtl/jam_cost_table_if.sv
// Bundle between the loader/solver side (master) and the cost table (slave):
// streaming table load, cost lookup and result capture.
interface jam_cost_table_if;
  import jam_pkg::*;

  logic                clr;
  logic                load_valid;
  logic [COST_W-1:0]   load_data;
  logic                load_ready;
  logic [IDX_W-1:0]    W;
  logic [IDX_W-1:0]    J;
  logic [COST_W-1:0]   Cost;
  logic                table_ready;
  logic                Valid;
  logic [SUM_W-1:0]    MinCost;
  logic [CNT_W-1:0]    MatchCount;
  logic [SUM_W-1:0]    res_min_cost;
  logic [CNT_W-1:0]    res_match_count;
  logic                done;

  modport master (
    output clr, load_valid, load_data, W, J, Valid, MinCost, MatchCount,
    input  load_ready, Cost, table_ready, res_min_cost, res_match_count, done
  );

  modport slave (
    input  clr, load_valid, load_data, W, J, Valid, MinCost, MatchCount,
    output load_ready, Cost, table_ready, res_min_cost, res_match_count, done
  );

endinterface

// File: rtl/jam_cost_table_cost_mem.sv
// 64 x 7 cost register file: one synchronous write port, one asynchronous read port.
// Storage is deliberately unreset so it maps onto plain flops or distributed RAM.
module cost_mem
  import jam_pkg::*;
(
  input  logic               CLK,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_addr,
  input  logic [COST_W-1:0]  wr_data,
  input  logic [PTR_W-1:0]   rd_addr,
  output logic [COST_W-1:0]  rd_data
);

  logic [COST_W-1:0] mem [N_ENTRY];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/jam_cost_table.sv
// Cost table feeding an assignment solver: streams in 64 costs, serves zero-latency
// (W,J) lookups once full, and captures the solver's first result.
module jam_cost_table
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_n,
  jam_cost_table_if.slave   bus
);

  state_t               state;
  logic [PTR_W-1:0]     wr_ptr;
  logic                 load_ready_q;
  logic                 table_ready_q;
  logic                 done_q;
  logic [SUM_W-1:0]     res_min_q;
  logic [CNT_W-1:0]     res_cnt_q;
  logic                 wr_en;
  logic [COST_W-1:0]    rd_cost;

  // clr wins over a coincident load beat, so the entry is never written.
  assign wr_en = bus.load_valid && load_ready_q && !bus.clr;

  cost_mem u_cost_mem (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (bus.load_data),
    .rd_addr (entry_addr(bus.W, bus.J)),
    .rd_data (rd_cost)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state         <= EMPTY;
      wr_ptr        <= '0;
      load_ready_q  <= 1'b0;
      table_ready_q <= 1'b0;
      done_q        <= 1'b0;
      res_min_q     <= '0;
      res_cnt_q     <= '0;
    end else if (bus.clr) begin
      state         <= LOAD;
      wr_ptr        <= '0;
      load_ready_q  <= 1'b1;
      table_ready_q <= 1'b0;
      done_q        <= 1'b0;
      res_min_q     <= '0;
      res_cnt_q     <= '0;
    end else begin
      case (state)
        EMPTY: begin
          state        <= LOAD;
          load_ready_q <= 1'b1;
        end
        LOAD: begin
          if (bus.load_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == PTR_W'(N_ENTRY - 1)) begin
              state         <= READY;
              load_ready_q  <= 1'b0;
              table_ready_q <= 1'b1;
            end
          end
        end
        READY: begin
          if (bus.Valid) begin
            state     <= DONE;
            done_q    <= 1'b1;
            res_min_q <= bus.MinCost;
            res_cnt_q <= bus.MatchCount;
          end
        end
        DONE: begin
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  // Lookups only expose stored data once the whole table is valid.
  assign bus.Cost            = table_ready_q ? rd_cost : '0;
  assign bus.load_ready      = load_ready_q;
  assign bus.table_ready     = table_ready_q;
  assign bus.done            = done_q;
  assign bus.res_min_cost    = res_min_q;
  assign bus.res_match_count = res_cnt_q;

endmodule

// File: tb/tb_jam_cost_table.sv
// Randomized scoreboard bench for jam_cost_table: each stimulus cycle pushes the
// expected outputs from a behavioural table model; a negedge monitor pops and compares.
module tb_jam_cost_table;
  import jam_pkg::*;

  typedef struct {
    bit       rst_n;
    bit       clr;
    bit       lv;
    bit [6:0] ld;
    bit [2:0] w;
    bit [2:0] j;
    bit       valid;
    bit [9:0] minc;
    bit [3:0] mcnt;
  } stim_t;

  typedef struct {
    bit       load_ready;
    bit       table_ready;
    bit       done;
    bit [6:0] cost;
    bit [9:0] res_min;
    bit [3:0] res_cnt;
  } exp_t;

  logic CLK   = 1'b0;
  logic RST_n = 1'b0;

  jam_cost_table_if bus();

  jam_cost_table dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];

  // Behavioural model: a table is "live" once out of reset, "full" after 64 accepted
  // entries, and holds at most one captured result until cleared.
  int ref_mem [64];
  int ref_count;
  bit ref_live;
  bit ref_full;
  bit ref_captured;
  int ref_min;
  int ref_cnt;

  function automatic void modelReset();
    ref_live     = 1'b0;
    ref_full     = 1'b0;
    ref_captured = 1'b0;
    ref_count    = 0;
    ref_min      = 0;
    ref_cnt      = 0;
  endfunction

  function automatic void modelStep(input stim_t s);
    if (!s.rst_n) return;
    if (s.clr) begin
      ref_live     = 1'b1;
      ref_full     = 1'b0;
      ref_captured = 1'b0;
      ref_count    = 0;
      ref_min      = 0;
      ref_cnt      = 0;
    end else if (!ref_live) begin
      ref_live = 1'b1;
    end else if (!ref_full) begin
      if (s.lv) begin
        ref_mem[ref_count] = int'(s.ld);
        ref_count = ref_count + 1;
        if (ref_count == 64) begin
          ref_full  = 1'b1;
          ref_count = 0;
        end
      end
    end else if (!ref_captured && s.valid) begin
      ref_captured = 1'b1;
      ref_min      = int'(s.minc);
      ref_cnt      = int'(s.mcnt);
    end
  endfunction

  function automatic exp_t modelOutputs(input stim_t s);
    exp_t e;
    e.load_ready  = ref_live && !ref_full;
    e.table_ready = ref_full;
    e.done        = ref_captured;
    e.cost        = ref_full ? 7'(ref_mem[int'(s.w) * 8 + int'(s.j)]) : 7'd0;
    e.res_min     = 10'(ref_min);
    e.res_cnt     = 4'(ref_cnt);
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1'b1;
    s.clr   = 1'b0;
    s.lv    = 1'b0;
    s.ld    = 7'd0;
    s.w     = 3'($urandom_range(0, 7));
    s.j     = 3'($urandom_range(0, 7));
    s.valid = 1'b0;
    s.minc  = 10'd0;
    s.mcnt  = 4'd0;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // Called at posedge+1: drive one cycle, publish its expectation, advance the model.
  task automatic applyStimulus(input stim_t s);
    RST_n          = s.rst_n;
    bus.clr        = s.clr;
    bus.load_valid = s.lv;
    bus.load_data  = s.ld;
    bus.W          = s.w;
    bus.J          = s.j;
    bus.Valid      = s.valid;
    bus.MinCost    = s.minc;
    bus.MatchCount = s.mcnt;
    if (!s.rst_n) modelReset();
    expQ.push_back(modelOutputs(s));
    @(posedge CLK);
    #1;
    modelStep(s);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(idle());
  endtask

  task automatic loadBackToBack(input int n, input bit random_data);
    stim_t s;
    for (int k = 0; k < n; k++) begin
      s    = idle();
      s.lv = 1'b1;
      s.ld = random_data ? 7'($urandom_range(0, 127)) : 7'(k % 100);
      applyStimulus(s);
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("load_ready",      32'(bus.load_ready),      32'(e.load_ready));
      checkOutput("table_ready",     32'(bus.table_ready),     32'(e.table_ready));
      checkOutput("done",            32'(bus.done),            32'(e.done));
      checkOutput("cost",            32'(bus.Cost),            32'(e.cost));
      checkOutput("res_min_cost",    32'(bus.res_min_cost),    32'(e.res_min));
      checkOutput("res_match_count", 32'(bus.res_match_count), 32'(e.res_cnt));
    end
  end

  initial begin
    stim_t s;
    bus.clr = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0;
    bus.W = '0; bus.J = '0; bus.Valid = 1'b0; bus.MinCost = '0; bus.MatchCount = '0;
    modelReset();
    @(posedge CLK);
    #1;

    // Reset, one EMPTY cycle, then 64 back-to-back entries k mod 100.
    s = idle(); s.rst_n = 1'b0;
    applyStimulus(s);
    applyStimulus(s);
    idleCycles(1);
    loadBackToBack(64, 1'b0);
    s = idle(); s.w = 3'd3; s.j = 3'd5;
    applyStimulus(s);
    idleCycles(12);

    // A load beat while READY must not disturb entry 0.
    s = idle(); s.lv = 1'b1; s.ld = 7'd127; s.w = 3'd0; s.j = 3'd0;
    applyStimulus(s);
    s = idle(); s.w = 3'd0; s.j = 3'd0;
    applyStimulus(s);

    // First result is kept; a later strobe in DONE is ignored.
    s = idle(); s.valid = 1'b1; s.minc = 10'd320; s.mcnt = 4'd2;
    applyStimulus(s);
    idleCycles(2);
    s = idle(); s.valid = 1'b1; s.minc = 10'd100; s.mcnt = 4'd5;
    applyStimulus(s);
    idleCycles(3);

    // Restart, then load with load_valid on every other cycle (and stray Valid strobes).
    s = idle(); s.clr = 1'b1;
    applyStimulus(s);
    for (int c = 0; c < 128; c++) begin
      s       = idle();
      s.lv    = (c % 2 == 0);
      s.ld    = 7'((c / 2) % 100);
      s.valid = (c % 5 == 0);
      s.minc  = 10'($urandom_range(0, 1023));
      applyStimulus(s);
    end
    s = idle(); s.w = 3'd7; s.j = 3'd7;
    applyStimulus(s);
    idleCycles(8);

    // clr together with Valid in READY: no capture.
    s = idle(); s.clr = 1'b1; s.valid = 1'b1; s.minc = 10'd777; s.mcnt = 4'd9;
    applyStimulus(s);

    // Random-rate load of random data, then random lookups and a random result.
    for (int c = 0; c < 400 && !ref_full; c++) begin
      s    = idle();
      s.lv = ($urandom_range(0, 9) < 7);
      s.ld = 7'($urandom_range(0, 127));
      applyStimulus(s);
    end
    idleCycles(12);
    s = idle(); s.valid = 1'b1;
    s.minc = 10'($urandom_range(0, 1023)); s.mcnt = 4'($urandom_range(0, 15));
    applyStimulus(s);
    idleCycles(2);

    // clr from DONE, 10 entries, then clr with a coincident load beat at wr_ptr 10.
    s = idle(); s.clr = 1'b1;
    applyStimulus(s);
    loadBackToBack(10, 1'b1);
    s = idle(); s.clr = 1'b1; s.lv = 1'b1; s.ld = 7'($urandom_range(0, 127));
    applyStimulus(s);
    loadBackToBack(64, 1'b1);
    s = idle(); s.w = 3'd1; s.j = 3'd2;
    applyStimulus(s);
    idleCycles(6);

    // Reset mid-load at wr_ptr 40; a full reload is needed afterwards.
    s = idle(); s.clr = 1'b1;
    applyStimulus(s);
    loadBackToBack(40, 1'b1);
    s = idle(); s.rst_n = 1'b0; s.lv = 1'b1; s.ld = 7'd55;
    applyStimulus(s);
    s.lv = 1'b0;
    applyStimulus(s);
    s = idle(); s.lv = 1'b1; s.ld = 7'd99;
    applyStimulus(s);
    loadBackToBack(63, 1'b1);
    idleCycles(2);
    loadBackToBack(1, 1'b1);
    idleCycles(10);
    s = idle(); s.valid = 1'b1;
    s.minc = 10'($urandom_range(0, 1023)); s.mcnt = 4'($urandom_range(0, 15));
    applyStimulus(s);
    idleCycles(3);

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
